// File: rtl/nios2_debug_jtag_scan_master_if.sv
// rtl/nios2_debug_jtag_scan_master_if.sv - request/response bundle for the JTAG scan master
// Purpose: groups the {IR, DR} scan request channel and the captured-TDO response channel.
// Ports (signals):
//   req_valid/req_ready/req_ir/req_dr  - scan request, IR and DR shifted LSB first
//   rsp_valid/rsp_ready/rsp_ir/rsp_dr  - captured TDO, bit i = i-th shifted bit
// Modports: master = requester side, slave = scan master side.
interface nios2_debug_jtag_scan_master_if #(
  parameter int IR_W = 2,
  parameter int DR_W = 38
);
  logic            req_valid;
  logic            req_ready;
  logic [IR_W-1:0] req_ir;
  logic [DR_W-1:0] req_dr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IR_W-1:0] rsp_ir;
  logic [DR_W-1:0] rsp_dr;

  modport master (
    output req_valid, req_ir, req_dr, rsp_ready,
    input  req_ready, rsp_valid, rsp_ir, rsp_dr
  );

  modport slave (
    input  req_valid, req_ir, req_dr, rsp_ready,
    output req_ready, rsp_valid, rsp_ir, rsp_dr
  );
endinterface

// File: rtl/nios2_debug_jtag_scan_master.sv
// rtl/nios2_debug_jtag_scan_master.sv - JTAG scan initiator for a 2-bit-IR / 38-bit-DR virtual TAP
// Purpose: walks the TAP to Run-Test/Idle after reset, then for each {IR, DR} request scans
//   IR and DR and returns the TDO bits captured during Shift-IR / Shift-DR.
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   bus (slave)      - request/response channels, see nios2_debug_jtag_scan_master_if
//   tck, tms, tdi    - JTAG outputs (tck idle low), tdo - JTAG input
// Optional feature: JTAG_SCAN_IR_CACHE_EN skips the IR leg when the requested IR equals
//   the last one scanned since reset.
module nios2_debug_jtag_scan_master #(
  parameter int IR_W    = 2,
  parameter int DR_W    = 38,
  parameter int TCK_DIV = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  nios2_debug_jtag_scan_master_if.slave   bus,
  output logic                            tck,
  output logic                            tms,
  output logic                            tdi,
  input  logic                            tdo
);
  localparam int NBITS      = 10 + IR_W + DR_W;
  localparam int MAXB       = (NBITS > 6) ? NBITS : 6;
  localparam int CW         = $clog2(MAXB);
  localparam int DW         = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  // Bit positions within the full scan sequence.
  localparam int IR_LO      = 4;
  localparam int IR_HI      = IR_W + 3;
  localparam int DR_LO      = IR_W + 8;
  localparam int DR_HI      = IR_W + 7 + DR_W;
  // An IR-cache hit enters the full sequence at the Select-DR step.
  localparam int SKIP_START = IR_W + 5;

  typedef enum logic [1:0] {TLR_SEQ, IDLE, SCAN, RESP} state_t;

  state_t          state, state_next;
  logic [DW-1:0]   div_cnt;
  logic [CW-1:0]   bit_idx;
  logic            scan_load;
  logic            req_ready_q;
  logic [IR_W-1:0] ir_q, cap_ir;
  logic [DR_W-1:0] dr_q, cap_dr;
  logic            half_tick, active, tck_fall, last_bit, accept, ir_hit;
  logic            seq_tms, seq_tdi;
  logic [CW-1:0]   start_idx;
  int              cur, seq_pos;

  assign half_tick = (div_cnt == DW'(TCK_DIV - 1));
  assign active    = (state == TLR_SEQ) || ((state == SCAN) && !scan_load);
  assign tck_fall  = active && half_tick && tck;
  assign last_bit  = (state == TLR_SEQ) ? (bit_idx == CW'(5)) : (bit_idx == CW'(NBITS - 1));
  assign accept    = (state == IDLE) && req_ready_q && bus.req_valid;
  assign start_idx = ir_hit ? CW'(SKIP_START) : '0;
  assign cur       = int'(bit_idx);
  // The first bit of a scan is loaded from bit_idx itself; later bits are preloaded at the fall.
  assign seq_pos   = scan_load ? cur : cur + 1;

`ifdef JTAG_SCAN_IR_CACHE_EN
  logic [IR_W-1:0] last_ir;
  logic            cache_vld;

  assign ir_hit = cache_vld && (bus.req_ir == last_ir);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ir   <= '0;
      cache_vld <= 1'b0;
    end else if (accept) begin
      last_ir   <= bus.req_ir;
      cache_vld <= 1'b1;
    end
  end
`else
  assign ir_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= TLR_SEQ;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR_SEQ: if (tck_fall && last_bit) state_next = IDLE;
      IDLE:    if (accept)               state_next = SCAN;
      SCAN:    if (tck_fall && last_bit) state_next = RESP;
      RESP:    if (bus.rsp_ready)        state_next = IDLE;
      default:                           state_next = TLR_SEQ;
    endcase
  end

  // tms/tdi for the bit at seq_pos.
  always_comb begin
    seq_tms = 1'b0;
    seq_tdi = 1'b0;
    if (state == TLR_SEQ) begin
      seq_tms = (seq_pos != 5);
    end else if (seq_pos < IR_LO) begin
      seq_tms = (seq_pos < 2);
    end else if (seq_pos <= IR_HI) begin
      seq_tdi = |(ir_q & (IR_W'(1) << (seq_pos - IR_LO)));
      seq_tms = (seq_pos == IR_HI);
    end else if (seq_pos < DR_LO) begin
      seq_tms = (seq_pos < IR_W + 6);
    end else if (seq_pos <= DR_HI) begin
      seq_tdi = |(dr_q & (DR_W'(1) << (seq_pos - DR_LO)));
      seq_tms = (seq_pos == DR_HI);
    end else begin
      seq_tms = (seq_pos == NBITS - 2);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Bit 0 of the reset sequence (tms=1) is on the wire straight out of reset.
      tck         <= 1'b0;
      tms         <= 1'b1;
      tdi         <= 1'b0;
      div_cnt     <= '0;
      bit_idx     <= '0;
      scan_load   <= 1'b0;
      req_ready_q <= 1'b0;
      ir_q        <= '0;
      dr_q        <= '0;
      cap_ir      <= '0;
      cap_dr      <= '0;
    end else begin
      case (state)
        TLR_SEQ, SCAN: begin
          if (scan_load) begin
            tms       <= seq_tms;
            tdi       <= seq_tdi;
            scan_load <= 1'b0;
            div_cnt   <= '0;
          end else if (half_tick) begin
            div_cnt <= '0;
            tck     <= ~tck;
            if (!tck) begin
              if (state == SCAN && cur >= IR_LO && cur <= IR_HI)
                cap_ir <= (cap_ir >> 1) | (IR_W'(tdo) << (IR_W - 1));
              if (state == SCAN && cur >= DR_LO && cur <= DR_HI)
                cap_dr <= (cap_dr >> 1) | (DR_W'(tdo) << (DR_W - 1));
            end else if (!last_bit) begin
              bit_idx <= bit_idx + CW'(1);
              tms     <= seq_tms;
              tdi     <= seq_tdi;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        IDLE: begin
          if (!req_ready_q) begin
            req_ready_q <= 1'b1;
          end else if (bus.req_valid) begin
            ir_q        <= bus.req_ir;
            dr_q        <= bus.req_dr;
            cap_ir      <= '0;
            cap_dr      <= '0;
            req_ready_q <= 1'b0;
            scan_load   <= 1'b1;
            div_cnt     <= '0;
            bit_idx     <= start_idx;
          end
        end
        RESP: begin
          if (bus.rsp_ready) req_ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_ir    = cap_ir;
  assign bus.rsp_dr    = cap_dr;
endmodule

// File: tb/tb_nios2_debug_jtag_scan_master.sv
// tb/tb_nios2_debug_jtag_scan_master.sv - randomized bench with a behavioural TAP model
module tb_nios2_debug_jtag_scan_master;
  localparam int IR_W    = 2;
  localparam int DR_W    = 38;
  localparam int TCK_DIV = 2;
  localparam int NBITS   = 10 + IR_W + DR_W;
  localparam logic [IR_W-1:0] CAP_IR = 2'b01;
  localparam logic [DR_W-1:0] CAP_DR = 38'h12_3456_789A;
`ifdef JTAG_SCAN_IR_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int TLR_S = 0, RTI_S = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PADR = 6,
                 EX2DR = 7, UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12,
                 PAIR = 13, EX2IR = 14, UPIR = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tck, tms, tdi, tdo;

  nios2_debug_jtag_scan_master_if #(.IR_W(IR_W), .DR_W(DR_W)) bus ();

  nios2_debug_jtag_scan_master #(.IR_W(IR_W), .DR_W(DR_W), .TCK_DIV(TCK_DIV)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .tck   (tck),
    .tms   (tms),
    .tdi   (tdi),
    .tdo   (tdo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Target TAP: standard 16-state controller sharing the system reset.
  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR_S:   return m ? TLR_S : RTI_S;
      RTI_S:   return m ? SELDR : RTI_S;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI_S;
      SELIR:   return m ? TLR_S : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI_S;
    endcase
  endfunction

  int              tap = TLR_S;
  logic [IR_W-1:0] ir_sr = '0, tap_ir = '0;
  logic [DR_W-1:0] dr_sr = '0, tap_dr = '0;
  int              pulses = 0;
  logic [5:0]      tms_hist = '0;
  time             last_rise = 0;
  int              per_bad = 0;

  always @(posedge tck or posedge reset) begin
    if (reset) begin
      tap = TLR_S;
    end else begin
      if (last_rise != 0 && ($time - last_rise) != 2 * TCK_DIV * 10) per_bad++;
      last_rise = $time;
      case (tap)
        CAPIR:   ir_sr = CAP_IR;
        SHIR:    ir_sr = {tdi, ir_sr[IR_W-1:1]};
        UPIR:    tap_ir = ir_sr;
        CAPDR:   dr_sr = CAP_DR;
        SHDR:    dr_sr = {tdi, dr_sr[DR_W-1:1]};
        UPDR:    tap_dr = dr_sr;
        default: ;
      endcase
      tap = tap_next(tap, tms);
      pulses++;
      tms_hist = {tms, tms_hist[5:1]};
    end
  end

  assign tdo = (tap == SHIR) ? ir_sr[0] : (tap == SHDR) ? dr_sr[0] : 1'b0;

  // tms/tdi must hold on every clk edge that raises tck.
  int viol = 0;
  always @(posedge clk) begin : edge_rule
    logic t0, m0, d0;
    t0 = tck; m0 = tms; d0 = tdi;
    #1;
    if (t0 === 1'b0 && tck === 1'b1 && (tms !== m0 || tdi !== d0)) viol++;
  end

  // Reference IR cache state.
  bit              m_vld = 1'b0;
  logic [IR_W-1:0] m_last = '0;

  function automatic logic [DR_W-1:0] rand_dr();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[DR_W-1:0];
  endfunction

  task automatic tlr_after_reset();
    int n = 0;
    pulses = 0;
    last_rise = 0;
    while (bus.req_ready !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("tlr_ready_clk", 64'(n), 64'(12 * TCK_DIV + 1));
    chk("tlr_pulses", 64'(pulses), 64'd6);
    chk("tlr_tms_seq", 64'(tms_hist), 64'b011111);
    chk("tlr_tap_rti", 64'(tap), 64'(RTI_S));
    chk("tlr_tdi", 64'(tdi), 64'd0);
  endtask

  task automatic issue(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 64'(n < 100), 64'd1);
    bus.req_ir = ir;
    bus.req_dr = dr;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    pulses = 0;
    last_rise = 0;
    chk("accept_ready_low", 64'(bus.req_ready), 64'd0);
  endtask

  task automatic run_scan(input logic [IR_W-1:0] ir, input logic [DR_W-1:0] dr, input int hold);
    bit hit;
    int nb, n, bad;
    logic [IR_W-1:0] eir;
    hit = CACHE && m_vld && (ir == m_last);
    nb  = hit ? 5 + DR_W : NBITS;
    eir = hit ? '0 : CAP_IR;
    m_vld = 1'b1;
    m_last = ir;
    issue(ir, dr);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 2 * TCK_DIV * NBITS + 50) begin
      @(posedge clk); #1; n++;
    end
    chk("rsp_latency", 64'(n), 64'(1 + 2 * TCK_DIV * nb));
    chk("tck_pulses", 64'(pulses), 64'(nb));
    chk("rsp_ir", 64'(bus.rsp_ir), 64'(eir));
    chk("rsp_dr", 64'(bus.rsp_dr), 64'(CAP_DR));
    chk("tap_ir", 64'(tap_ir), 64'(ir));
    chk("tap_dr", 64'(tap_dr), 64'(dr));
    chk("tap_rti", 64'(tap), 64'(RTI_S));
    bad = 0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_ir !== eir || bus.rsp_dr !== CAP_DR ||
          tck !== 1'b0 || bus.req_ready !== 1'b0) bad++;
    end
    chk("hold_stable", 64'(bad), 64'd0);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_consumed", 64'(bus.rsp_valid), 64'd0);
    chk("ready_after_rsp", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic mid_reset();
    logic [IR_W-1:0] ir;
    logic [DR_W-1:0] dr, saved;
    int pre, n, seen;
    ir = IR_W'($urandom_range(0, 3));
    dr = rand_dr();
    pre = (CACHE && m_vld && ir == m_last) ? 3 : 8 + IR_W;
    saved = tap_dr;
    issue(ir, dr);
    n = 0;
    seen = 0;
    while (pulses < pre + 21 && n < 1000) begin
      @(posedge clk); #1; n++;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    chk("dr_bit20_reached", 64'(pulses), 64'(pre + 21));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_vld = 1'b0;
    chk("mid_rst_tck", 64'(tck), 64'd0);
    chk("mid_rst_tms", 64'(tms), 64'd1);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    tlr_after_reset();
    chk("mid_rst_no_rsp", 64'(seen + int'(bus.rsp_valid)), 64'd0);
    chk("mid_rst_dr_kept", 64'(tap_dr), 64'(saved));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_ir = '0;
    bus.req_dr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_ir", 64'(bus.rsp_ir), 64'd0);
    chk("rst_rsp_dr", 64'(bus.rsp_dr), 64'd0);
    reset = 1'b0;
    tlr_after_reset();

    run_scan(2'b10, 38'h2A_AAAA_5555, 10);
    run_scan(2'b10, rand_dr(), 0);
    run_scan(2'b11, rand_dr(), 3);
    for (int i = 0; i < 8; i++)
      run_scan(IR_W'($urandom_range(0, 3)), rand_dr(), int'($urandom_range(0, 4)));
    mid_reset();
    run_scan(IR_W'($urandom_range(0, 3)), rand_dr(), 2);

    chk("tck_edge_rule", 64'(viol), 64'd0);
    chk("tck_period", 64'(per_bad), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
